q9_seq_ctrl: RTL and testbench
==============================

# q9_seq_ctrl

Run controller for the two-flip-flop (A, B) state machine with inputs x, y and output z. The block holds a programmed list of (x, y) input pairs and replays it into the attached machine at one pair per clock. It resets the machine before each run and logs z on every step. At the end it captures the final {A, B} state and signals completion, so a bench or host can exercise the machine without hand-timing stimulus.

## Interface
Parameters:
- DEPTH, 8, maximum number of (x, y) steps per run (power of 2, 2..32)
- PTR_W, 3, log2(DEPTH)

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  append wr_xy to the step buffer
- wr_xy  in  2  step data: [1] = x, [0] = y
- clr  in  1  empty the step buffer (count := 0)
- start  in  1  begin a run
- fsm_A, fsm_B  in  1 each  current state bits of the attached machine
- fsm_z  in  1  output of the attached machine (may be Mealy)
- fsm_reset  out  1  reset to the attached machine
- fsm_x, fsm_y  out  1 each  inputs to the attached machine (registered)
- busy  out  1  run in progress
- done  out  1  one-cycle completion pulse
- full  out  1  count == DEPTH
- count  out  PTR_W+1  number of programmed steps
- z_log  out  DEPTH  z_log[k] = z sampled on step k
- final_AB  out  2  {A, B} after the last step

## Operation
- FSM states: IDLE, RST, RUN, SETTLE.
- Reset values: state = IDLE, count = 0, idx = 0, fsm_reset = 0, fsm_x = fsm_y = 0, busy = 0, done = 0, z_log = 0, final_AB = 0. Buffer contents are don't-care.
- IDLE:
  - wr_en with !full: buf[count] := wr_xy, count += 1.
  - wr_en with full: ignored; count holds.
  - clr: count := 0.
  - start with count > 0 and no clr: go to RST. wr_en in the same cycle is ignored.
  - start with count == 0: ignored.
  - clr and start together: clr wins; start ignored.
- RST (1 cycle): fsm_reset = 1, busy = 1, z_log := 0.
- RUN (count cycles): fsm_reset = 0, {fsm_x, fsm_y} = buf[idx].
  - At each edge: z_log[idx] := fsm_z, idx += 1.
  - At idx == count−1: go to SETTLE.
- SETTLE (1 cycle): fsm_x = fsm_y = 0. At exit edge: final_AB := {fsm_A, fsm_B}, done := 1, go to IDLE.
- Unwritten z_log bits (k ≥ count) stay 0.
- busy = 1 in RST, RUN and SETTLE. While busy, wr_en, clr and start are ignored.
- Buffer and count are retained after a run. start again replays the identical list.
- idx compare uses the PTR_W+1-bit count, so count == DEPTH runs all DEPTH steps without wrap.

## Timing
- Let E0 be the edge sampling an accepted start.
  - After E0: fsm_reset = 1.
  - After E1: step 0 is driven.
  - After Ek+1: step k is driven; z for step k is sampled at edge Ek+2.
  - After Ecount+1: SETTLE.
  - After Ecount+2: done = 1 for exactly one cycle, busy = 0, final_AB and z_log valid.
- Start-to-done latency is count + 2 cycles.
- fsm_x, fsm_y and fsm_reset come from flops; there is no combinational path from inputs to them.
- fsm_z is sampled in the same cycle its step is driven, which supports Mealy z.
- reset mid-run: next cycle is IDLE with all reset values, including count = 0. A run is never resumed.
- done is never asserted for a run interrupted by reset.

## Test plan
- Program (0,0),(0,1),(1,0),(1,1), start. Stub fsm_z = fsm_x ^ fsm_y. Expect:
  - fsm_reset high for 1 cycle.
  - fsm_x/fsm_y show 00, 01, 10, 11 on consecutive cycles.
  - z_log = 4'b0110 (bit k = step k).
  - done 6 cycles after the start edge; busy low the same cycle.
- Fill with DEPTH = 8 writes of 2'b10, then a 9th write. Expect full = 1, count = 8, the 9th write ignored, and a run of 8 steps with done after 10 cycles.
- start with count = 0, and clr with start in the same cycle. Expect state stays IDLE, busy = 0, no done.
- Assert wr_en, clr and start during a run. Expect count unchanged, no restart, and the run completes normally.
- Assert reset at step 2 of a 4-step run. Expect all outputs at reset values next cycle, count = 0, no done pulse.
- Stub fsm_A/fsm_B = 1/0 during SETTLE. Expect final_AB = 2'b10 when done pulses. A second start without reprogramming replays the same sequence.

Source files
------------

// File: rtl/q9_seq_ctrl.sv
// Replays a programmed list of (x, y) steps into an attached two-flop machine,
// logging z per step and capturing the final {A, B} state on completion.
module q9_seq_ctrl #(
  parameter int DEPTH = 8,
  parameter int PTR_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [1:0]       wr_xy,
  input  logic             clr,
  input  logic             start,
  input  logic             fsm_A,
  input  logic             fsm_B,
  input  logic             fsm_z,
  output logic             fsm_reset,
  output logic             fsm_x,
  output logic             fsm_y,
  output logic             busy,
  output logic             done,
  output logic             full,
  output logic [PTR_W:0]   count,
  output logic [DEPTH-1:0] z_log,
  output logic [1:0]       final_AB
);

  typedef enum logic [1:0] {IDLE, RST, RUN, SETTLE} state_t;

  state_t           state, state_next;
  logic [1:0]       step_mem [DEPTH];
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] idx_nxt;
  logic             accept;
  logic             wr_ok;
  logic             last_step;

  assign full      = (count == (PTR_W+1)'(DEPTH));
  assign busy      = (state != IDLE);
  // clr beats start, and an accepted start swallows a same-cycle write.
  assign accept    = (state == IDLE) && start && !clr && (count != '0);
  assign wr_ok     = (state == IDLE) && wr_en && !clr && !accept && !full;
  assign idx_nxt   = idx + 1'b1;
  // Compare against the wide count so a full buffer never wraps early.
  assign last_step = ({1'b0, idx} == (count - 1'b1));

  always_comb begin
    // NOTE: next-state defaults to the current state first so no path leaves it unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = RST;
      RST:     state_next = RUN;
      RUN:     if (last_step) state_next = SETTLE;
      SETTLE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count     <= '0;
      idx       <= '0;
      fsm_reset <= 1'b0;
      fsm_x     <= 1'b0;
      fsm_y     <= 1'b0;
      done      <= 1'b0;
      z_log     <= '0;
      final_AB  <= 2'b00;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clr)        count <= '0;
          else if (wr_ok) count <= count + 1'b1;
          if (accept) begin
            fsm_reset <= 1'b1;
            idx       <= '0;
          end
        end
        RST: begin
          fsm_reset      <= 1'b0;
          z_log          <= '0;
          {fsm_x, fsm_y} <= step_mem[0];
        end
        RUN: begin
          z_log[idx] <= fsm_z;
          idx        <= idx_nxt;
          if (last_step) {fsm_x, fsm_y} <= 2'b00;
          else           {fsm_x, fsm_y} <= step_mem[idx_nxt];
        end
        SETTLE: begin
          final_AB <= {fsm_A, fsm_B};
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the step buffer has no reset; its contents only matter below count.
  always_ff @(posedge clk) begin
    if (wr_ok) step_mem[count[PTR_W-1:0]] <= wr_xy;
  end

endmodule

// File: tb/tb_q9_seq_ctrl.sv
// Self-checking bench for q9_seq_ctrl: directed plan cases plus randomized runs
// checked against a list-based model of programming and run timing.
module tb_q9_seq_ctrl;

  localparam int DEPTH = 8;
  localparam int PTR_W = 3;

  logic             clk = 1'b0;
  logic             reset, wr_en, clr, start, fsm_A, fsm_B, fsm_z;
  logic [1:0]       wr_xy;
  logic             fsm_reset, fsm_x, fsm_y, busy, done, full;
  logic [PTR_W:0]   count;
  logic [DEPTH-1:0] z_log;
  logic [1:0]       final_AB;

  logic [3:0]       z_tt;      // stub z truth table indexed by {x, y}
  logic [1:0]       ab_val;    // {A, B} the stub presents during SETTLE
  logic [1:0]       model_q [$];
  int               tests = 0;
  int               fails = 0;

  always #5 clk = ~clk;

  assign fsm_z = z_tt[{fsm_x, fsm_y}];

  q9_seq_ctrl #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_xy(wr_xy), .clr(clr),
    .start(start), .fsm_A(fsm_A), .fsm_B(fsm_B), .fsm_z(fsm_z),
    .fsm_reset(fsm_reset), .fsm_x(fsm_x), .fsm_y(fsm_y), .busy(busy),
    .done(done), .full(full), .count(count), .z_log(z_log), .final_AB(final_AB)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " count"}, count, model_q.size());
    check({tag, " full"}, full, model_q.size() == DEPTH);
  endtask

  task automatic wr(input logic [1:0] xy);
    wr_en = 1'b1; wr_xy = xy;
    tick();
    wr_en = 1'b0;
    if (model_q.size() < DEPTH) model_q.push_back(xy);
    check("wr count", count, model_q.size());
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
    model_q.delete();
    check("clr count", count, 0);
  endtask

  // Start a run and check every cycle up to one past the done pulse.
  task automatic do_run(input bit inject);
    int n;
    logic [DEPTH-1:0] exp_z;
    n = model_q.size();
    exp_z = '0;
    for (int k = 0; k < n; k++) exp_z[k] = z_tt[model_q[k]];
    {fsm_A, fsm_B} = ~ab_val;
    start = 1'b1;
    tick();
    start = inject;
    if (inject) begin
      wr_en = 1'b1; clr = 1'b1; wr_xy = 2'($urandom);
    end
    check("rst pulse", fsm_reset, 1);
    check("rst busy", busy, 1);
    check("rst xy", {fsm_x, fsm_y}, 0);
    for (int k = 0; k < n; k++) begin
      tick();
      check("step rst", fsm_reset, 0);
      check("step xy", {fsm_x, fsm_y}, model_q[k]);
      check("step busy", busy, 1);
      check("step done", done, 0);
    end
    {fsm_A, fsm_B} = ab_val;
    tick();
    check("settle xy", {fsm_x, fsm_y}, 0);
    check("settle busy", busy, 1);
    check("settle done", done, 0);
    tick();
    wr_en = 1'b0; clr = 1'b0; start = 1'b0;
    check("done pulse", done, 1);
    check("done busy", busy, 0);
    check("z_log", z_log, exp_z);
    check("final_AB", final_AB, ab_val);
    check("run count", count, n);
    tick();
    check("done low", done, 0);
    check("post busy", busy, 0);
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; clr = 1'b0; start = 1'b0; wr_xy = 2'b00;
    fsm_A = 1'b0; fsm_B = 1'b0; z_tt = 4'b0110; ab_val = 2'b10;
    tick(); tick();
    check("reset count", count, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset outs", {fsm_reset, fsm_x, fsm_y, full}, 0);
    check("reset z_log", z_log, 0);
    check("reset final", final_AB, 0);
    reset = 1'b0;
    tick();

    // XOR stub on the four input combinations, then replay unchanged.
    wr(2'b00); wr(2'b01); wr(2'b10); wr(2'b11);
    do_run(0);
    check("xor z_log", z_log, 8'b0000_0110);
    ab_val = 2'b01;
    do_run(0);

    // Fill to capacity, one write beyond, run all DEPTH steps.
    do_clr();
    for (int i = 0; i < DEPTH + 1; i++) wr(2'b10);
    check("full flag", full, 1);
    check("full count", count, DEPTH);
    z_tt = 4'b0100;
    do_run(0);

    // start on an empty buffer, and clr together with start.
    do_clr();
    start = 1'b1; tick(); start = 1'b0;
    check_idle("empty start");
    tick();
    check_idle("empty start+1");
    wr(2'b11);
    clr = 1'b1; start = 1'b1; tick(); clr = 1'b0; start = 1'b0;
    model_q.delete();
    check_idle("clr+start");
    tick();
    check_idle("clr+start+1");

    // Host traffic during a run is ignored.
    wr(2'b01); wr(2'b11); wr(2'b00);
    z_tt = 4'b1010; ab_val = 2'b11;
    do_run(1);
    check_idle("after inject");

    // Reset while step 2 of a 4-step run is driven.
    do_clr();
    wr(2'b01); wr(2'b10); wr(2'b11); wr(2'b01);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    check("pre-reset xy", {fsm_x, fsm_y}, 2'b11);
    reset = 1'b1; tick(); reset = 1'b0;
    model_q.delete();
    check("midrst outs", {fsm_reset, fsm_x, fsm_y, busy, done, full}, 0);
    check("midrst z_log", z_log, 0);
    check("midrst final", final_AB, 0);
    check_idle("midrst");
    for (int i = 0; i < 8; i++) begin
      tick();
      check_idle("midrst quiet");
    end

    // Randomized programming and runs.
    for (int it = 0; it < 30; it++) begin
      int n;
      do_clr();
      n = $urandom_range(1, DEPTH) + $urandom_range(0, 2);
      for (int i = 0; i < n; i++) wr(2'($urandom));
      z_tt = 4'($urandom);
      ab_val = 2'($urandom);
      do_run(1'($urandom));
      if ($urandom_range(0, 2) == 0) begin
        ab_val = 2'($urandom);
        do_run(0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
